// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, start/busy/done handshake.
// Quotient truncates toward zero; remainder carries the dividend's sign.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] rem_r, dvd_r, dvs_r;
  logic [CW-1:0]    cnt;
  logic             qsign, rsign, dz;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   trial;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the exact magnitude.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign trial   = {rem_r, dvd_r[WIDTH-1]} - {1'b0, dvs_r};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? FIX : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_r       <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      cnt         <= '0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvs_r <= dvs_mag;
          qsign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rsign <= dividend[WIDTH-1];
          cnt   <= CW'(WIDTH);
          dz    <= (divisor == '0);
          // On divide-by-zero the dividend magnitude parks in the remainder so FIX restores it.
          if (divisor == '0) begin
            rem_r <= dvd_mag;
            dvd_r <= '0;
          end else begin
            rem_r <= '0;
            dvd_r <= dvd_mag;
          end
        end
        CALC: begin
          if (!trial[WIDTH]) rem_r <= trial[WIDTH-1:0];
          else               rem_r <= {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
          dvd_r <= {dvd_r[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          quotient    <= dz ? '1 : (qsign ? -dvd_r : dvd_r);
          remainder   <= rsign ? -rem_r : rem_r;
          div_by_zero <= dz;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_seq_divider;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn32, st32, bz32, dn32, dz32;
  logic [31:0] a32, b32, q32, r32;
  logic        rn8, st8, bz8, dn8, dz8;
  logic [7:0]  a8, b8, q8, r8;

  seq_divider #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(rn32), .start(st32), .dividend(a32), .divisor(b32),
    .busy(bz32), .done(dn32), .quotient(q32), .remainder(r32), .div_by_zero(dz32));

  seq_divider #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(rn8), .start(st8), .dividend(a8), .divisor(b8),
    .busy(bz8), .done(dn8), .quotient(q8), .remainder(r8), .div_by_zero(dz8));

  int checks = 0;
  int failures = 0;

  typedef struct {longint q; longint r; bit dz;} exp_t;
  exp_t e32[$], e8[$];
  exp_t m32, m8;

  function automatic longint sx(longint v, int w);
    longint m = (longint'(1) << w) - 1;
    v = v & m;
    if (((v >> (w - 1)) & 1) != 0) return v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: language-level signed division (truncating) wrapped to w bits.
  function automatic exp_t model(longint pa, longint pb, int w);
    exp_t e;
    longint mask = (longint'(1) << w) - 1;
    longint a = sx(pa, w);
    longint b = sx(pb, w);
    if (b == 0) begin
      e.q = mask; e.r = a & mask; e.dz = 1'b1;
    end else begin
      e.q = (a / b) & mask; e.r = (a % b) & mask; e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic longint pick(int w);
    longint mask = (longint'(1) << w) - 1;
    case ($urandom_range(0, 7))
      0: return 0;
      1: return longint'(1) << (w - 1);
      2: return mask;
      3: return (longint'(1) << (w - 1)) - 1;
      4: return 1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dn32) begin
      chk("busy_with_done32", longint'(bz32), 0);
      if (e32.size() == 0) chk("unexpected_done32", 1, 0);
      else begin
        m32 = e32.pop_front();
        chk("quotient32", longint'(q32), m32.q);
        chk("remainder32", longint'(r32), m32.r);
        chk("dbz32", longint'(dz32), longint'(m32.dz));
      end
    end
    if (dn8) begin
      chk("busy_with_done8", longint'(bz8), 0);
      if (e8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        m8 = e8.pop_front();
        chk("quotient8", longint'(q8), m8.q);
        chk("remainder8", longint'(r8), m8.r);
        chk("dbz8", longint'(dz8), longint'(m8.dz));
      end
    end
  end

  task automatic wait_done32(output int cyc, output int bc);
    cyc = 0;
    bc  = int'(bz32);
    while (!dn32 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bz32) bc++;
    end
    if (!dn32) chk("timeout32", 0, 1);
  endtask

  task automatic div32(input logic [31:0] a, input logic [31:0] b, output int cyc, output int bc);
    @(negedge clk);
    a32 = a; b32 = b; st32 = 1'b1;
    e32.push_back(model(longint'(a), longint'(b), 32));
    @(posedge clk); #1;
    st32 = 1'b0;
    wait_done32(cyc, bc);
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b, output int cyc);
    @(negedge clk);
    a8 = a; b8 = b; st8 = 1'b1;
    e8.push_back(model(longint'(a), longint'(b), 8));
    @(posedge clk); #1;
    st8 = 1'b0;
    cyc = 0;
    while (!dn8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!dn8) chk("timeout8", 0, 1);
  endtask

  initial begin
    int cyc, bc, dcnt;
    logic [31:0] ra, rb;
    logic [7:0]  sa, sb;
    rn32 = 1'b0; rn8 = 1'b0; st32 = 1'b0; st8 = 1'b0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", longint'(bz32), 0);
    chk("rst_done", longint'(dn32), 0);
    chk("rst_q", longint'(q32), 0);
    chk("rst_r", longint'(r32), 0);
    chk("rst_dz", longint'(dz32), 0);
    @(negedge clk);
    rn32 = 1'b1; rn8 = 1'b1;

    div32(32'd100, 32'd7, cyc, bc);
    chk("lat_100_7", cyc, 33);
    chk("busy_cycles_100_7", bc, 33);
    @(posedge clk); #1;
    chk("done_one_cycle", longint'(dn32), 0);

    div32(-32'sd100, 32'd7, cyc, bc);
    div32(32'd100, -32'sd7, cyc, bc);
    div32(-32'sd100, -32'sd7, cyc, bc);
    div32(32'h8000_0000, 32'hFFFF_FFFF, cyc, bc);
    chk("lat_overflow", cyc, 33);
    div32(32'h8000_0000, 32'd1, cyc, bc);
    div32(32'd55, 32'd0, cyc, bc);
    chk("lat_dbz", cyc, 1);
    chk("busy_cycles_dbz", bc, 1);
    div32(32'd9, 32'd3, cyc, bc);

    // start pulsed mid-division with other operands must be ignored
    @(negedge clk);
    a32 = 32'd1000; b32 = 32'd33; st32 = 1'b1;
    e32.push_back(model(64'd1000, 64'd33, 32));
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a32 = 32'd3; b32 = 32'd1; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    wait_done32(cyc, bc);
    chk("lat_ignored_start", cyc, 27);

    // start held through the done cycle: back-to-back divisions
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; st32 = 1'b1;
    e32.push_back(model(64'd100, 64'd7, 32));
    @(posedge clk); #1;
    a32 = -32'sd9; b32 = 32'd4;
    wait_done32(cyc, bc);
    chk("lat_b2b_first", cyc, 33);
    e32.push_back(model(longint'(32'hFFFF_FFF7), 64'd4, 32));
    @(posedge clk); #1;
    st32 = 1'b0;
    chk("busy_b2b_second", longint'(bz32), 1);
    wait_done32(cyc, bc);
    chk("lat_b2b_second", cyc, 33);

    // reset at cycle 10 of a division
    @(negedge clk);
    a32 = 32'd1000; b32 = 32'd3; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rn32 = 1'b0;
    #1;
    chk("midrst_busy", longint'(bz32), 0);
    chk("midrst_done", longint'(dn32), 0);
    chk("midrst_q", longint'(q32), 0);
    chk("midrst_r", longint'(r32), 0);
    chk("midrst_dz", longint'(dz32), 0);
    @(negedge clk);
    rn32 = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dn32) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);
    div32(32'd7, 32'd7, cyc, bc);
    chk("lat_after_rst", cyc, 33);

    fork
      begin
        repeat (600) begin
          ra = 32'(pick(32));
          rb = 32'(pick(32));
          div32(ra, rb, cyc, bc);
          chk("lat_rand32", cyc, (rb == '0) ? 1 : 33);
        end
      end
      begin
        repeat (600) begin
          sa = 8'(pick(8));
          sb = 8'(pick(8));
          div8(sa, sb, cyc);
          chk("lat_rand8", cyc, (sb == '0) ? 1 : 9);
        end
      end
    join
    repeat (3) @(posedge clk);
    chk("pending32", e32.size(), 0);
    chk("pending8", e8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
